// File: rtl/jtdd2_snd_romarb.sv
// rtl/jtdd2_snd_romarb.sv - SDRAM read-slot arbiter for the DD2 sound CPU ROM and ADPCM ROM
//
// Two requesters (sound Z80 program ROM, MSM6295 sample ROM) share one SDRAM
// read port. Each requester owns a one-byte tagged cache, so a repeated read
// of the same address is answered combinationally without touching SDRAM.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   downloading            ROM load in progress: flush caches, abort, stay idle
//   cpu_cs/cpu_addr        CPU ROM read request and byte address
//   cpu_data/cpu_ok        cached byte and its validity for cpu_addr
//   pcm_cs/pcm_addr        ADPCM ROM read request and byte address
//   pcm_data/pcm_ok        cached byte and its validity for pcm_addr
//   sdram_req/sdram_addr   read request and global byte address to SDRAM
//   sdram_ack              request accepted (1-cycle pulse)
//   sdram_rdy/sdram_data   read data strobe and byte

module jtdd2_snd_romarb #(
  parameter logic [21:0] CPU_OFFSET = 22'h00_0000,
  parameter logic [21:0] PCM_OFFSET = 22'h00_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        cpu_cs,
  input  logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_ok,
  input  logic        pcm_cs,
  input  logic [17:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [7:0]  sdram_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t      state;

  logic        cpu_valid;
  logic [14:0] cpu_tag;
  logic        pcm_valid;
  logic [17:0] pcm_tag;

  // gnt_pcm: owner of the transaction in flight; last_pcm: owner of the
  // previous grant, used to break ties round-robin.
  logic        gnt_pcm;
  logic        last_pcm;
  // Tag captured at grant time. The fill always uses this, never the live
  // address, so a requester that moves its address mid-transaction cannot
  // get the old byte labelled with the new address.
  logic [17:0] req_tag;

  logic        cpu_hit;
  logic        pcm_hit;
  logic        pend_cpu;
  logic        pend_pcm;
  logic        pick_pcm;
  logic        fill;
  logic [21:0] cpu_gaddr;
  logic [21:0] pcm_gaddr;

  assign cpu_hit  = cpu_valid && (cpu_tag == cpu_addr);
  assign pcm_hit  = pcm_valid && (pcm_tag == pcm_addr);
  assign cpu_ok   = cpu_cs && cpu_hit;
  assign pcm_ok   = pcm_cs && pcm_hit;

  assign pend_cpu = cpu_cs && !cpu_hit;
  assign pend_pcm = pcm_cs && !pcm_hit;
  // PCM wins only when it is alone or the CPU had the previous slot.
  assign pick_pcm = pend_pcm && (!pend_cpu || !last_pcm);

  // Global SDRAM byte addresses; the sums wrap at 22 bits.
  assign cpu_gaddr = CPU_OFFSET + {7'd0, cpu_addr};
  assign pcm_gaddr = PCM_OFFSET + {4'd0, pcm_addr};

  // Data can arrive together with the acknowledge; both cases fill the cache.
  assign fill = sdram_rdy &&
                ((state == WAIT_DATA) || ((state == WAIT_ACK) && sdram_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      cpu_valid  <= 1'b0;
      cpu_tag    <= 15'd0;
      cpu_data   <= 8'd0;
      pcm_valid  <= 1'b0;
      pcm_tag    <= 18'd0;
      pcm_data   <= 8'd0;
      gnt_pcm    <= 1'b0;
      last_pcm   <= 1'b1;
      req_tag    <= 18'd0;
    end else if (downloading) begin
      // ROM contents are changing: drop any transaction in flight (its data
      // is discarded) and forget everything cached.
      state     <= IDLE;
      sdram_req <= 1'b0;
      cpu_valid <= 1'b0;
      pcm_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_cpu || pend_pcm) begin
            gnt_pcm    <= pick_pcm;
            last_pcm   <= pick_pcm;
            req_tag    <= pick_pcm ? pcm_addr : {3'd0, cpu_addr};
            sdram_addr <= pick_pcm ? pcm_gaddr : cpu_gaddr;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= sdram_rdy ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (sdram_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase

      if (fill) begin
        if (gnt_pcm) begin
          pcm_valid <= 1'b1;
          pcm_tag   <= req_tag;
          pcm_data  <= sdram_data;
        end else begin
          cpu_valid <= 1'b1;
          cpu_tag   <= req_tag[14:0];
          cpu_data  <= sdram_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtdd2_snd_romarb.sv
// tb/tb_jtdd2_snd_romarb.sv - self-checking bench for jtdd2_snd_romarb
module tb_jtdd2_snd_romarb;

  localparam logic [21:0] CPU_OFF = 22'h00_0000;
  localparam logic [21:0] PCM_OFF = 22'h00_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        cpu_cs = 1'b0;
  logic [14:0] cpu_addr = 15'd0;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic        pcm_cs = 1'b0;
  logic [17:0] pcm_addr = 18'd0;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        sdram_rdy = 1'b0;
  logic [7:0]  sdram_data = 8'd0;

  int errors = 0;
  int checks = 0;

  jtdd2_snd_romarb #(.CPU_OFFSET(CPU_OFF), .PCM_OFFSET(PCM_OFF)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_data(sdram_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Contents of the simulated SDRAM.
  function automatic logic [7:0] mem(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  task automatic wait_req(input string nm, input logic [21:0] exp_addr);
    int n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " req"}, sdram_req, 1);
    chk({nm, " addr"}, sdram_addr, exp_addr);
  endtask

  // Entered at the negedge where sdram_req is first seen; ack 1 cycle later,
  // rdy 3 cycles after that; returns at the negedge after the rdy edge.
  task automatic serve(input string nm, input logic is_pcm, input logic [7:0] d);
    logic [21:0] a;
    a = sdram_addr;
    tick();
    chk({nm, " req held"}, sdram_req, 1);
    chk({nm, " addr held"}, sdram_addr, a);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk({nm, " req drop"}, sdram_req, 0);
    tick();
    tick();
    chk({nm, " no early ok"}, is_pcm ? pcm_ok : cpu_ok, 0);
    sdram_rdy  = 1'b1;
    sdram_data = d;
    tick();
    sdram_rdy = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    cpu_cs = 1'b0; pcm_cs = 1'b0; downloading = 1'b0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        is_pcm;
    logic [17:0] addr;
    logic [21:0] exp_sdram;
    logic [7:0]  data;
  } vec_t;

  vec_t vt[5];

  // Reference model for the random phase.
  logic        m_cv, m_pv, m_last, cur_pcm, fill_pend, exp_idle, pc, pp, g;
  logic [14:0] m_ct;
  logic [17:0] m_pt;
  logic [7:0]  m_cd, m_pd;
  logic [21:0] cur_addr, ea, diff;
  int          ph, cnt;

  initial begin
    vt[0] = '{1'b0, 18'h00123, 22'h000123, 8'hA5};
    vt[1] = '{1'b1, 18'h3FFFF, 22'h047FFF, 8'h3C};
    vt[2] = '{1'b0, 18'h07FFF, 22'h007FFF, 8'h81};
    vt[3] = '{1'b1, 18'h00000, 22'h008000, 8'h0F};
    vt[4] = '{1'b0, 18'h00000, 22'h000000, 8'hE7};

    // Reset state, requests held high to show nothing is cached yet.
    cpu_cs = 1'b1; pcm_cs = 1'b1;
    tick(); tick();
    chk("rst req", sdram_req, 0);
    chk("rst addr", sdram_addr, 0);
    chk("rst cpu_data", cpu_data, 0);
    chk("rst pcm_data", pcm_data, 0);
    chk("rst cpu_ok", cpu_ok, 0);
    chk("rst pcm_ok", pcm_ok, 0);
    cpu_cs = 1'b0; pcm_cs = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single misses, address translation, then hits with no new request.
    for (int i = 0; i < 5; i++) begin
      cpu_cs = !vt[i].is_pcm;
      pcm_cs = vt[i].is_pcm;
      if (vt[i].is_pcm) pcm_addr = vt[i].addr;
      else cpu_addr = vt[i].addr[14:0];
      #1;
      chk("vec miss ok", vt[i].is_pcm ? pcm_ok : cpu_ok, 0);
      wait_req("vec", vt[i].exp_sdram);
      serve("vec", vt[i].is_pcm, vt[i].data);
      chk("vec ok", vt[i].is_pcm ? pcm_ok : cpu_ok, 1);
      chk("vec data", vt[i].is_pcm ? pcm_data : cpu_data, vt[i].data);
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("vec hit no req", sdram_req, 0);
        chk("vec hit ok", vt[i].is_pcm ? pcm_ok : cpu_ok, 1);
      end
      cpu_cs = 1'b0; pcm_cs = 1'b0;
    end

    // Both pending from reset: CPU first, then strict alternation.
    do_reset();
    cpu_addr = 15'h0050; pcm_addr = 18'h00060;
    cpu_cs = 1'b1; pcm_cs = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        wait_req("alt cpu", CPU_OFF + {7'd0, cpu_addr});
        serve("alt cpu", 1'b0, 8'h10 + 8'(i));
        chk("alt cpu ok", cpu_ok, 1);
        chk("alt cpu data", cpu_data, 8'h10 + 8'(i));
        cpu_addr = cpu_addr + 15'd1;
      end else begin
        wait_req("alt pcm", PCM_OFF + {4'd0, pcm_addr});
        serve("alt pcm", 1'b1, 8'h20 + 8'(i));
        chk("alt pcm ok", pcm_ok, 1);
        chk("alt pcm data", pcm_data, 8'h20 + 8'(i));
        pcm_addr = pcm_addr + 18'd1;
      end
    end

    // Address change during WAIT_DATA: fill keeps the original tag.
    pcm_cs = 1'b0;
    cpu_addr = 15'h0010;
    wait_req("chg first", 22'h000010);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    cpu_addr = 15'h0011;
    tick();
    sdram_rdy = 1'b1; sdram_data = 8'h77;
    tick();
    sdram_rdy = 1'b0;
    chk("chg stale ok", cpu_ok, 0);
    cpu_addr = 15'h0010;
    #1;
    chk("chg tag0010 ok", cpu_ok, 1);
    chk("chg tag0010 data", cpu_data, 8'h77);
    tick();
    cpu_addr = 15'h0011;
    wait_req("chg second", 22'h000011);
    serve("chg second", 1'b0, 8'h88);
    chk("chg second ok", cpu_ok, 1);
    chk("chg second data", cpu_data, 8'h88);

    // ack and rdy in the same cycle.
    cpu_addr = 15'h0020;
    wait_req("ackrdy", 22'h000020);
    tick();
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 8'h5C;
    tick();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    chk("ackrdy ok", cpu_ok, 1);
    chk("ackrdy data", cpu_data, 8'h5C);
    chk("ackrdy req", sdram_req, 0);
    cpu_addr = 15'h0021;
    wait_req("ackrdy next", 22'h000021);
    serve("ackrdy next", 1'b0, 8'h5D);
    chk("ackrdy next data", cpu_data, 8'h5D);

    // downloading during WAIT_ACK, with an in-flight rdy that must be dropped.
    cpu_addr = 15'h0030;
    wait_req("dl cpu", 22'h000030);
    serve("dl cpu", 1'b0, 8'h4D);
    pcm_cs = 1'b1; pcm_addr = 18'h00100;
    wait_req("dl pcm", 22'h008100);
    serve("dl pcm", 1'b1, 8'h99);
    chk("dl both ok cpu", cpu_ok, 1);
    chk("dl both ok pcm", pcm_ok, 1);
    cpu_addr = 15'h0031;
    wait_req("dl miss", 22'h000031);
    downloading = 1'b1;
    sdram_rdy = 1'b1; sdram_data = 8'hEE;
    tick();
    sdram_rdy = 1'b0;
    chk("dl req drop", sdram_req, 0);
    chk("dl cpu_ok", cpu_ok, 0);
    chk("dl pcm_ok", pcm_ok, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dl hold no req", sdram_req, 0);
    end
    pcm_cs = 1'b0;
    cpu_addr = 15'h0030;
    downloading = 1'b0;
    #1;
    chk("dl flushed ok", cpu_ok, 0);
    wait_req("dl refetch", 22'h000030);
    serve("dl refetch", 1'b0, 8'h4E);
    chk("dl refetch data", cpu_data, 8'h4E);

    // Asynchronous reset mid-transaction.
    cpu_addr = 15'h0040;
    wait_req("arst", 22'h000040);
    #2 rst_n = 1'b0;
    #1;
    chk("arst req", sdram_req, 0);
    chk("arst addr", sdram_addr, 0);
    chk("arst cpu_data", cpu_data, 0);
    chk("arst cpu_ok", cpu_ok, 0);
    cpu_cs = 1'b0;
    tick();
    rst_n = 1'b1;

    // Random phase against a transaction-level model.
    m_cv = 0; m_pv = 0; m_ct = 0; m_pt = 0; m_cd = 0; m_pd = 0;
    m_last = 1'b1; ph = 0; cnt = 0; fill_pend = 0; exp_idle = 1; pc = 0; pp = 0;
    cur_pcm = 0; cur_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (fill_pend) begin
        if (cur_pcm) begin
          diff = cur_addr - PCM_OFF;
          m_pv = 1; m_pt = diff[17:0]; m_pd = mem(cur_addr);
        end else begin
          diff = cur_addr - CPU_OFF;
          m_cv = 1; m_ct = diff[14:0]; m_cd = mem(cur_addr);
        end
        fill_pend = 0;
      end
      chk("rnd cpu_ok", cpu_ok, cpu_cs && m_cv && (m_ct == cpu_addr));
      chk("rnd pcm_ok", pcm_ok, pcm_cs && m_pv && (m_pt == pcm_addr));
      if (cpu_ok) chk("rnd cpu_data", cpu_data, m_cd);
      if (pcm_ok) chk("rnd pcm_data", pcm_data, m_pd);
      sdram_ack = 1'b0; sdram_rdy = 1'b0;
      if (ph == 0) begin
        if (exp_idle && (pc || pp)) begin
          g  = pp && (!pc || !m_last);
          ea = g ? PCM_OFF + {4'd0, pcm_addr} : CPU_OFF + {7'd0, cpu_addr};
          chk("rnd grant req", sdram_req, 1);
          chk("rnd grant addr", sdram_addr, ea);
          m_last = g; cur_pcm = g; cur_addr = ea;
          ph = 1; cnt = $urandom_range(0, 3);
        end else begin
          chk("rnd idle req", sdram_req, 0);
        end
      end else if (ph == 1) begin
        chk("rnd req held", sdram_req, 1);
        chk("rnd addr held", sdram_addr, cur_addr);
      end else begin
        chk("rnd req low", sdram_req, 0);
      end
      if (ph == 1) begin
        if (cnt == 0) begin
          sdram_ack = 1'b1;
          if ($urandom_range(0, 2) == 0) begin
            sdram_rdy = 1'b1; sdram_data = mem(cur_addr); fill_pend = 1; ph = 0;
          end else begin
            ph = 2; cnt = $urandom_range(0, 3);
          end
        end else cnt--;
      end else if (ph == 2) begin
        if (cnt == 0) begin
          sdram_rdy = 1'b1; sdram_data = mem(cur_addr); fill_pend = 1; ph = 0;
        end else cnt--;
      end else if ($urandom_range(0, 15) == 0) begin
        sdram_rdy = 1'b1; sdram_data = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) cpu_cs = !cpu_cs;
      if ($urandom_range(0, 3) == 0) pcm_cs = !pcm_cs;
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: cpu_addr = 15'h0010;
          1: cpu_addr = 15'h0011;
          2: cpu_addr = 15'h7FFF;
          default: cpu_addr = 15'($urandom);
        endcase
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: pcm_addr = 18'h00000;
          1: pcm_addr = 18'h3FFFF;
          2: pcm_addr = 18'h00100;
          default: pcm_addr = 18'($urandom);
        endcase
      end
      pc = cpu_cs && !(m_cv && (m_ct == cpu_addr));
      pp = pcm_cs && !(m_pv && (m_pt == pcm_addr));
      exp_idle = (ph == 0) && !fill_pend;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdd2_snd_romarb.md
Name: jtdd2_snd_romarb

Overview:
Arbiter sharing one SDRAM read slot between the sound Z80 program ROM fetch port and the MSM6295 ADPCM sample fetch port of the DD2 sound subsystem. Each requester keeps a one-byte tagged cache, so repeated reads of the same address complete without an SDRAM access. The block sits between the sound CPU/ADPCM cores and the SDRAM controller port, and translates each requester's local address into a global SDRAM byte address by adding a per-region offset.

Parameters:
CPU_OFFSET, 22'h00_0000, SDRAM byte base of the sound program ROM region
PCM_OFFSET, 22'h00_8000, SDRAM byte base of the ADPCM sample region

Ports:
clk  input  1  system clock, 48 MHz
rst_n  input  1  asynchronous active-low reset
downloading  input  1  ROM load in progress; flushes the block and holds it idle
cpu_cs  input  1  CPU ROM read request
cpu_addr  input  15  CPU ROM byte address
cpu_data  output  8  cached byte for cpu_addr
cpu_ok  output  1  cpu_data is valid for the current cpu_addr
pcm_cs  input  1  ADPCM ROM read request
pcm_addr  input  18  ADPCM ROM byte address
pcm_data  output  8  cached byte for pcm_addr
pcm_ok  output  1  pcm_data is valid for the current pcm_addr
sdram_req  output  1  read request to the SDRAM controller
sdram_addr  output  22  SDRAM byte address
sdram_ack  input  1  request accepted (1-cycle pulse)
sdram_rdy  input  1  read data valid (1-cycle pulse)
sdram_data  input  8  read data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sdram_req=0, sdram_addr=0, cpu_data=pcm_data=0.
  - Both caches invalid; FSM in IDLE; last_grant=PCM, so the first tie goes to the CPU.
- Cache per requester: valid bit, address tag, data byte.
  - hit_x = valid_x & (tag_x == addr_x).
  - x_ok = x_cs & hit_x. This is combinational from registered state, so a hit gives 0-cycle latency.
  - x_data is driven from the registered cache byte.
- pend_x = x_cs & ~hit_x, evaluated in IDLE only.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
  - IDLE:
    - Neither pending: stay in IDLE.
    - One pending: grant it.
    - Both pending: grant the requester that is not last_grant (round robin).
    - On a grant, register the grant, the address tag and sdram_addr:
      - CPU: CPU_OFFSET + zero-extended cpu_addr.
      - PCM: PCM_OFFSET + zero-extended pcm_addr.
      - The sum is taken mod 2^22.
    - Also on a grant: set sdram_req=1, update last_grant, go to WAIT_ACK.
  - WAIT_ACK:
    - Hold sdram_req and sdram_addr stable until sdram_ack=1.
    - When sdram_ack=1, clear sdram_req on the next edge and go to WAIT_DATA.
    - If sdram_ack and sdram_rdy arrive in the same cycle, capture the data and return directly to IDLE.
  - WAIT_DATA:
    - When sdram_rdy=1, write sdram_data and the registered tag into the granted cache, set its valid bit, and go to IDLE.
    - sdram_rdy outside WAIT_ACK/WAIT_DATA is ignored.
- Address change mid-transaction:
  - The fetch completes and fills the cache with the original tag; the new address then misses and is fetched in turn.
  - x_ok must not assert for a stale tag.
- cs deasserted mid-transaction: the transaction still completes and the cache is filled.
- Minimum miss latency: request in IDLE, edge into WAIT_ACK, then the SDRAM latency, then the fill edge. x_ok rises the cycle after the sdram_rdy edge.
- downloading=1 (synchronous):
  - Force the FSM to IDLE, sdram_req=0, and invalidate both caches in the cycle it is sampled.
  - While high, no grants are issued.
  - An in-flight sdram_rdy is discarded.
- Back-to-back: the FSM re-arbitrates in the IDLE cycle after a fill. There is no bubble beyond that one IDLE cycle.

Test Plan:
- Reset then cpu_cs=1, cpu_addr=15'h0123, both other requesters idle:
  - sdram_req rises with sdram_addr=22'h000123.
  - ack after 2 cycles, rdy with 8'hA5 after 3 more.
  - Required: cpu_ok=1 and cpu_data=8'hA5 the cycle after rdy.
  - Holding the same address: no further sdram_req.
- PCM miss with pcm_addr=18'h3FFFF, default offset:
  - sdram_addr=22'h047FFF.
  - pcm_ok rises only after sdram_rdy.
- Both pending from reset:
  - CPU is granted first, then PCM.
  - With both missing continuously on new addresses, grants strictly alternate CPU, PCM, CPU, PCM.
- cpu_addr changes from 15'h0010 to 15'h0011 during WAIT_DATA:
  - The fill tags 0010.
  - cpu_ok stays 0.
  - A second request for 0011 is issued, and cpu_ok rises after its rdy.
- sdram_ack and sdram_rdy pulse in the same cycle: cache filled and FSM back in IDLE on the next edge, with no hang.
- downloading pulsed during WAIT_ACK:
  - sdram_req drops and both ok outputs go 0.
  - After downloading falls, a previously cached address misses and is refetched.
  - Assert rst_n low mid-transaction: all outputs return to 0 asynchronously.
